// File: rtl/ps2_key_emitter_if.sv
// Key-event request and status handshake between a key source and the PS/2 emitter.
interface ps2_key_emitter_if;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_release;
    logic       ready;
    logic       done;

    modport master (output key_valid, key_code, key_release, input ready, done);
    modport slave  (input key_valid, key_code, key_release, output ready, done);
endinterface

// File: rtl/ps2_key_emitter.sv
// Device-side PS/2 keyboard emulator: key event -> scancode bytes -> open-drain
// device-to-host frames with a locally generated PS2_CLK.
//   state    | meaning
//   IDLE     | ready for a key event, lines released
//   WAIT_BUS | lines released, waiting for PS2_CLK high two cycles running
//   BIT_HIGH | PS2_CLK released, data bit presented
//   BIT_LOW  | PS2_CLK pulled low, data bit held for the host to sample
//   GAP      | lines released between bytes
module ps2_key_emitter #(
    parameter int CLK_HALF   = 2500,
    parameter int GAP_CYCLES = 5000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    ps2_key_emitter_if.slave key_if,
    inout  wire              PS2_CLK,
    inout  wire              PS2_DAT
);
    localparam int HW = $clog2(CLK_HALF);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, GAP} state_t;
    state_t state_q, state_d;

    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    data_idx;
    logic [1:0]    byte_idx, seq_len, code_q;
    logic [7:0]    cur_byte;
    logic          rel_q, bus_free, clk_meta, clk_s;
    logic          frame_bit, accept, phase_end, gap_end, last_byte, inhibit;
    logic          clk_drv, dat_drv;

    always_ff @(posedge CLOCK_50) begin
        clk_meta <= PS2_CLK;
        clk_s    <= clk_meta;
    end

    assign accept    = (state_q == IDLE) && key_if.key_valid && (key_if.key_code != 2'd3);
    assign phase_end = (half_cnt == HW'(CLK_HALF - 1));
    assign gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign last_byte = (byte_idx == seq_len - 2'd1);
    // The first two cycles of a high half are skipped: clk_s still shows our own low phase.
    assign inhibit   = (state_q == BIT_HIGH) && (32'(half_cnt) >= 32'd2) && !clk_s;

    always_comb begin
        cur_byte = 8'h5A;
        if (code_q == 2'd0) begin
            if (rel_q && byte_idx == 2'd0) cur_byte = 8'hF0;
        end else if (byte_idx == 2'd0) begin
            cur_byte = 8'hE0;
        end else if (rel_q && byte_idx == 2'd1) begin
            cur_byte = 8'hF0;
        end else begin
            cur_byte = (code_q == 2'd1) ? 8'h6B : 8'h74;
        end
    end

    assign data_idx = 3'(bit_idx - 4'd1);

    always_comb begin
        frame_bit = 1'b1;
        if (bit_idx == 4'd0)      frame_bit = 1'b0;
        else if (bit_idx <= 4'd8) frame_bit = cur_byte[data_idx];
        else if (bit_idx == 4'd9) frame_bit = ~^cur_byte;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = WAIT_BUS;
            WAIT_BUS: if (clk_s && bus_free) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (inhibit)        state_d = WAIT_BUS;
                else if (phase_end) state_d = BIT_LOW;
            end
            BIT_LOW:  if (phase_end) state_d = (bit_idx == 4'd10) ? GAP : BIT_HIGH;
            GAP:      if (gap_end) state_d = last_byte ? IDLE : WAIT_BUS;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            half_cnt <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            seq_len  <= 2'd1;
            code_q   <= '0;
            rel_q    <= 1'b0;
            bus_free <= 1'b0;
        end else begin
            half_cnt <= (state_d != state_q || (state_q != BIT_HIGH && state_q != BIT_LOW))
                        ? '0 : half_cnt + HW'(1);
            gap_cnt  <= (state_q == GAP && state_d == GAP) ? gap_cnt + GW'(1) : '0;
            bus_free <= (state_q == WAIT_BUS) && (state_d == WAIT_BUS) && clk_s;
            if (state_q == WAIT_BUS)
                bit_idx <= '0;
            else if (state_q == BIT_LOW && phase_end && bit_idx != 4'd10)
                bit_idx <= bit_idx + 4'd1;
            if (accept) begin
                code_q   <= key_if.key_code;
                rel_q    <= key_if.key_release;
                seq_len  <= 2'd1 + {1'b0, key_if.key_code != 2'd0} + {1'b0, key_if.key_release};
                byte_idx <= '0;
            end else if (state_q == GAP && gap_end && !last_byte) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        clk_drv        = 1'b0;
        dat_drv        = 1'b0;
        key_if.ready   = 1'b0;
        key_if.done    = 1'b0;
        case (state_q)
            IDLE:     key_if.ready = 1'b1;
            BIT_HIGH: dat_drv = !frame_bit;
            BIT_LOW: begin
                clk_drv = 1'b1;
                dat_drv = !frame_bit;
            end
            GAP:      key_if.done = gap_end && last_byte;
            default:  ;
        endcase
    end

    assign PS2_CLK = clk_drv ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drv ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_key_emitter.sv
// Bench for ps2_key_emitter: pulled-up host lines, falling-edge frame sampler,
// expected-byte scoreboard checked per scenario.
module tb_ps2_key_emitter;
    localparam int CLK_HALF   = 4;
    localparam int GAP_CYCLES = 8;
    localparam int BYTE_CYC   = 22 * CLK_HALF + GAP_CYCLES;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    logic host_inh = 1'b0;
    wire  ps2_clk, ps2_dat;

    ps2_key_emitter_if kif();

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = host_inh ? 1'b0 : 1'bz;

    ps2_key_emitter #(.CLK_HALF(CLK_HALF), .GAP_CYCLES(GAP_CYCLES)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key_if   (kif),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int compared = 0, mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [10:0] rx_q[$];
    int          idle_q[$];
    logic [10:0] shreg = '0;
    int nbits = 0, done_cnt = 0, fall_cnt = 0, idle_run = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
    logic prev_clk = 1'b1, prev_dat = 1'b1;

    // Host side: sample data on each PS2_CLK falling edge, note start bits and idle runs.
    always @(negedge CLOCK_50) begin
        cyc++;
        if (kif.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (!resetn || host_inh) begin
            nbits = 0;
        end else if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            shreg[nbits[3:0]] = ps2_dat;
            fall_cnt++;
            nbits++;
            if (nbits == 11) begin rx_q.push_back(shreg); nbits = 0; end
        end else if (nbits == 0 && ps2_clk === 1'b1 && prev_dat === 1'b1 && ps2_dat === 1'b0) begin
            start_cyc = cyc;
            idle_q.push_back(idle_run);
        end
        idle_run = (ps2_clk === 1'b1 && ps2_dat === 1'b1) ? idle_run + 1 : 0;
        prev_clk = ps2_clk;
        prev_dat = ps2_dat;
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int target, input int budget, output bit to);
        int n = 0;
        while (done_cnt < target && n < budget) begin tick(); n++; end
        to = (done_cnt < target);
    endtask

    task automatic wait_rx(input int target, input int budget, output bit to);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin tick(); n++; end
        to = (rx_q.size() < target);
    endtask

    task automatic wait_bits(input int target, input int budget, output bit to);
        int n = 0;
        while (nbits != target && n < budget) begin tick(); n++; end
        to = (nbits != target);
    endtask

    task automatic push_seq(input logic [1:0] code, input logic rel);
        if (code == 2'd0) begin
            if (rel) exp_q.push_back(8'hF0);
            exp_q.push_back(8'h5A);
        end else begin
            exp_q.push_back(8'hE0);
            if (rel) exp_q.push_back(8'hF0);
            exp_q.push_back(code == 2'd1 ? 8'h6B : 8'h74);
        end
    endtask

    task automatic send(input logic [1:0] code, input logic rel);
        kif.key_valid = 1'b1; kif.key_code = code; kif.key_release = rel;
        push_seq(code, rel);
        tick();
        kif.key_valid = 1'b0;
    endtask

    task automatic poke(input logic [1:0] code, input logic rel);
        kif.key_valid = 1'b1; kif.key_code = code; kif.key_release = rel;
        tick();
        kif.key_valid = 1'b0;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        ticks(3);
        compared++; if (kif.ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", kif.ready); end
        compared++; if (kif.done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", kif.done); end
        compared++; if (ps2_clk !== 1'b1) begin mismatched++; $display("FAIL reset_clk: got %b want 1", ps2_clk); end
        compared++; if (ps2_dat !== 1'b1) begin mismatched++; $display("FAIL reset_dat: got %b want 1", ps2_dat); end
        resetn = 1'b1;
        ticks(4);
        compared++; if (kif.ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_after: got %b want 1", kif.ready); end
    endtask

    task automatic test_enter_make();
        logic [10:0] e, r;
        bit to;
        int d0 = done_cnt, f0 = fall_cnt;
        send(2'd0, 1'b0);
        compared++; if (kif.ready !== 1'b0) begin mismatched++; $display("FAIL enter_busy: got ready %b want 0", kif.ready); end
        wait_done(d0 + 1, 400, to);
        compared++; if (to) begin mismatched++; $display("FAIL enter_done_timeout: got %0d dones want %0d", done_cnt - d0, 1); end
        compared++; if (done_cyc - start_cyc + 1 != BYTE_CYC) begin mismatched++; $display("FAIL enter_latency: got %0d want %0d", done_cyc - start_cyc + 1, BYTE_CYC); end
        compared++; if (fall_cnt - f0 != 11) begin mismatched++; $display("FAIL enter_falls: got %0d want 11", fall_cnt - f0); end
        tick();
        compared++; if (kif.ready !== 1'b1) begin mismatched++; $display("FAIL enter_ready_after: got %b want 1", kif.ready); end
        compared++; if (kif.done !== 1'b0) begin mismatched++; $display("FAIL enter_done_width: got %b want 0", kif.done); end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL enter_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL enter_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_right_break();
        logic [10:0] e, r;
        bit to;
        int d0 = done_cnt;
        idle_q.delete();
        send(2'd2, 1'b1);
        wait_done(d0 + 1, 600, to);
        compared++; if (to) begin mismatched++; $display("FAIL rbrk_done_timeout: got %0d dones want 1", done_cnt - d0); end
        ticks(20);
        compared++; if (done_cnt != d0 + 1) begin mismatched++; $display("FAIL rbrk_done_count: got %0d want 1", done_cnt - d0); end
        compared++; if (idle_q.size() != 3) begin mismatched++; $display("FAIL rbrk_starts: got %0d want 3", idle_q.size()); end
        for (int i = 1; i < 3; i++) begin
            compared++;
            if (((idle_q.size() > i) ? idle_q[i] : -1) != GAP_CYCLES + 2) begin
                mismatched++;
                $display("FAIL rbrk_gap%0d: got %0d idle cycles want %0d", i, (idle_q.size() > i) ? idle_q[i] : -1, GAP_CYCLES + 2);
            end
        end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL rbrk_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL rbrk_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_ignored();
        logic [10:0] e, r;
        bit to;
        int d0 = done_cnt;
        send(2'd1, 1'b0);
        ticks(30);
        poke(2'd0, 1'b1);
        ticks(40);
        poke(2'd2, 1'b0);
        wait_done(d0 + 1, 400, to);
        compared++; if (to) begin mismatched++; $display("FAIL ign_done_timeout: got %0d dones want 1", done_cnt - d0); end
        tick();
        for (int i = 0; i < 4; i++) begin
            poke(2'd3, i[0]);
            compared++; if (kif.ready !== 1'b1) begin mismatched++; $display("FAIL ign_code3_ready: got %b want 1", kif.ready); end
        end
        ticks(250);
        compared++; if (done_cnt != d0 + 1) begin mismatched++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL ign_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL ign_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_inhibit();
        logic [10:0] e, r;
        bit to;
        int n = 0;
        int d0 = done_cnt;
        send(2'd1, 1'b0);
        wait_rx(1, 300, to);
        compared++; if (to) begin mismatched++; $display("FAIL inh_first_byte_timeout: got %0d frames want 1", rx_q.size()); end
        wait_bits(6, 200, to);
        compared++; if (to) begin mismatched++; $display("FAIL inh_bits_timeout: got %0d bits want 6", nbits); end
        while (ps2_clk !== 1'b1 && n < 20) begin tick(); n++; end
        host_inh = 1'b1;
        ticks(10);
        compared++; if (ps2_dat !== 1'b1) begin mismatched++; $display("FAIL inh_dat_released: got %b want 1", ps2_dat); end
        compared++; if (kif.ready !== 1'b0) begin mismatched++; $display("FAIL inh_busy: got ready %b want 0", kif.ready); end
        ticks(10);
        host_inh = 1'b0;
        tick();
        compared++; if (ps2_clk !== 1'b1) begin mismatched++; $display("FAIL inh_clk_released: got %b want 1", ps2_clk); end
        wait_done(d0 + 1, 400, to);
        compared++; if (to) begin mismatched++; $display("FAIL inh_done_timeout: got %0d dones want 1", done_cnt - d0); end
        ticks(20);
        compared++; if (done_cnt != d0 + 1) begin mismatched++; $display("FAIL inh_done_count: got %0d want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL inh_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL inh_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e, r;
        bit to;
        int d0 = done_cnt;
        send(2'd2, 1'b1);
        wait_rx(1, 300, to);
        compared++; if (to) begin mismatched++; $display("FAIL rst_first_byte_timeout: got %0d frames want 1", rx_q.size()); end
        e = mk_frame(exp_q.pop_front());
        r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
        compared++; if (r !== e) begin mismatched++; $display("FAIL rst_first_frame: got %b want %b", r, e); end
        wait_bits(4, 200, to);
        compared++; if (to) begin mismatched++; $display("FAIL rst_bits_timeout: got %0d bits want 4", nbits); end
        resetn = 1'b0;
        tick();
        compared++; if (ps2_clk !== 1'b1) begin mismatched++; $display("FAIL rst_mid_clk: got %b want 1", ps2_clk); end
        compared++; if (ps2_dat !== 1'b1) begin mismatched++; $display("FAIL rst_mid_dat: got %b want 1", ps2_dat); end
        compared++; if (kif.ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready: got %b want 1", kif.ready); end
        compared++; if (kif.done !== 1'b0) begin mismatched++; $display("FAIL rst_mid_done: got %b want 0", kif.done); end
        resetn = 1'b1;
        exp_q.delete();
        rx_q.delete();
        ticks(5);
        send(2'd0, 1'b0);
        wait_done(d0 + 1, 400, to);
        compared++; if (to) begin mismatched++; $display("FAIL rst_done_timeout: got %0d dones want 1", done_cnt - d0); end
        ticks(150);
        compared++; if (done_cnt != d0 + 1) begin mismatched++; $display("FAIL rst_done_count: got %0d want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL rst_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL rst_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e, r;
        bit to, seen = 1'b0;
        int hi = 0, n = 0;
        int d0 = done_cnt;
        kif.key_valid = 1'b1; kif.key_code = 2'd0; kif.key_release = 1'b0;
        push_seq(2'd0, 1'b0);
        tick();
        compared++; if (kif.ready !== 1'b0) begin mismatched++; $display("FAIL b2b_busy: got ready %b want 0", kif.ready); end
        kif.key_code = 2'd1; kif.key_release = 1'b1;
        push_seq(2'd1, 1'b1);
        while (n < 600 && !(seen && kif.ready === 1'b0)) begin
            tick();
            n++;
            if (kif.ready === 1'b1) begin
                hi++;
                if (!seen) begin
                    compared++; if (done_cnt != d0 + 1) begin mismatched++; $display("FAIL b2b_first_done: got %0d want 1", done_cnt - d0); end
                end
                seen = 1'b1;
            end
        end
        kif.key_valid = 1'b0;
        compared++; if (!seen || hi != 1) begin mismatched++; $display("FAIL b2b_ready_window: got %0d cycles want 1", hi); end
        wait_done(d0 + 2, 600, to);
        compared++; if (to) begin mismatched++; $display("FAIL b2b_done_timeout: got %0d dones want 2", done_cnt - d0); end
        ticks(20);
        compared++; if (done_cnt != d0 + 2) begin mismatched++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = mk_frame(exp_q.pop_front());
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            compared++; if (r !== e) begin mismatched++; $display("FAIL b2b_frame: got %b want %b", r, e); end
        end
        compared++; if (rx_q.size() != 0) begin mismatched++; $display("FAIL b2b_extra: got %0d frames want 0", rx_q.size()); end
    endtask

    initial begin
        kif.key_valid   = 1'b0;
        kif.key_code    = 2'd0;
        kif.key_release = 1'b0;
        test_reset();
        test_enter_make();
        test_right_break();
        test_ignored();
        test_inhibit();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish within 40000 cycles want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
